calc1_port_scheduler: RTL

Front-end scheduler for the calc1 datapath. It accepts two-cycle operation requests on four independent ports and holds one captured request per port. A round-robin arbiter shares a single registered ALU/shifter between the ports, and each port's result and response code are returned on that port's own output pins. The block replaces per-port execution hardware with one shared execution unit behind a fair arbiter.

---
 rtl/calc1_pkg.sv | 26 ++
 rtl/calc1_port_scheduler_if.sv | 20 ++
 rtl/calc1_alu.sv | 66 ++++++
 rtl/calc1_port_scheduler.sv | 118 +++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared types and constants for the calc1 port scheduler and its ALU.
package calc1_pkg;
  localparam int NPORTS = 4;
  localparam int DW     = 32;

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_PEND,
    ST_EXEC
  } port_state_e;
endpackage

// File: rtl/calc1_port_scheduler_if.sv
// Requester-side bus of the calc1 scheduler: four command ports, their responses and drop flags.
interface calc1_port_scheduler_if;
  import calc1_pkg::*;

  logic [0:3]    req_cmd_in  [1:NPORTS];
  logic [0:DW-1] req_data_in [1:NPORTS];
  logic [0:1]    out_resp    [1:NPORTS];
  logic [0:DW-1] out_data    [1:NPORTS];
  logic [1:NPORTS] drop_err;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, drop_err
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, drop_err
  );
endinterface

// File: rtl/calc1_alu.sv
// Single registered ALU/shifter stage shared by all ports; the tag names the port the result belongs to.
module calc1_alu
  import calc1_pkg::*;
(
  input  logic          c_clk,
  input  logic          reset_n,
  input  logic [0:3]    cmd,
  input  logic [0:DW-1] a,
  input  logic [0:DW-1] b,
  input  logic          valid,
  input  logic [0:1]    tag,
  output logic [0:1]    resp,
  output logic [0:DW-1] data,
  output logic [0:1]    res_tag
);

  logic [0:DW]   sum;
  resp_e         nxt_resp;
  logic [0:DW-1] nxt_data;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    nxt_resp = RESP_ERR;
    nxt_data = '0;
    case (cmd)
      CMD_ADD: begin
        if (!sum[0]) begin
          nxt_resp = RESP_OK;
          nxt_data = sum[1:DW];
        end
      end
      CMD_SUB: begin
        if (b <= a) begin
          nxt_resp = RESP_OK;
          nxt_data = a - b;
        end
      end
      CMD_SHL: begin
        nxt_resp = RESP_OK;
        nxt_data = a << b[DW-5:DW-1];
      end
      CMD_SHR: begin
        nxt_resp = RESP_OK;
        nxt_data = a >> b[DW-5:DW-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      resp    <= '0;
      data    <= '0;
      res_tag <= '0;
    end else begin
      res_tag <= tag;
      if (valid) begin
        resp <= nxt_resp;
        data <= nxt_data;
      end else begin
        resp <= '0;
        data <= '0;
      end
    end
  end
endmodule

// File: rtl/calc1_port_scheduler.sv
// Four-port capture front end with a round-robin arbiter feeding one shared calc1_alu.
//
//   state   | meaning
//   IDLE    | waiting for a nonzero cmd; cmd and operand1 are captured
//   OP2     | operand2 captured unconditionally, cmd ignored
//   PEND    | requesting the ALU; a nonzero cmd here is dropped and flagged
//   EXEC    | ALU holds this port's op; a cmd now starts the next operation
module calc1_port_scheduler
  import calc1_pkg::*;
(
  input logic c_clk,
  input logic reset_n,
  calc1_port_scheduler_if.slave bus
);

  port_state_e   state [NPORTS];
  logic [0:3]    cap_cmd [NPORTS];
  logic [0:DW-1] cap_a [NPORTS];
  logic [0:DW-1] cap_b [NPORTS];
  logic [0:1]    last_ptr;
  logic [0:NPORTS-1] drop_err_q;

  logic          grant_vld;
  logic [0:1]    grant_idx;
  logic [0:3]    alu_cmd;
  logic [0:DW-1] alu_a;
  logic [0:DW-1] alu_b;
  logic [0:1]    alu_resp;
  logic [0:DW-1] alu_data;
  logic [0:1]    alu_tag;

  // Search begins one past the last grant, so after reset (last = port 4) port 1 wins first.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_ptr;
    for (int k = 1; k <= NPORTS; k++) begin
      if (!grant_vld && state[2'(int'(last_ptr) + k)] == ST_PEND) begin
        grant_vld = 1'b1;
        grant_idx = 2'(int'(last_ptr) + k);
      end
    end
  end

  always_comb begin
    alu_cmd = cap_cmd[grant_idx];
    alu_a   = cap_a[grant_idx];
    alu_b   = cap_b[grant_idx];
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        state[i]   <= ST_IDLE;
        cap_cmd[i] <= '0;
        cap_a[i]   <= '0;
        cap_b[i]   <= '0;
      end
      last_ptr   <= 2'd3;
      drop_err_q <= '0;
    end else begin
      if (grant_vld)
        last_ptr <= grant_idx;
      for (int i = 0; i < NPORTS; i++) begin
        case (state[i])
          // EXEC is the response cycle; accepting here gives one op per 3 cycles per port.
          ST_IDLE, ST_EXEC: begin
            if (bus.req_cmd_in[i+1] != '0) begin
              cap_cmd[i] <= bus.req_cmd_in[i+1];
              cap_a[i]   <= bus.req_data_in[i+1];
              state[i]   <= ST_OP2;
            end else begin
              state[i]   <= ST_IDLE;
            end
          end
          ST_OP2: begin
            cap_b[i] <= bus.req_data_in[i+1];
            state[i] <= ST_PEND;
          end
          ST_PEND: begin
            if (bus.req_cmd_in[i+1] != '0)
              drop_err_q[i] <= 1'b1;
            if (grant_vld && grant_idx == 2'(i))
              state[i] <= ST_EXEC;
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  calc1_alu u_alu (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .cmd     (alu_cmd),
    .a       (alu_a),
    .b       (alu_b),
    .valid   (grant_vld),
    .tag     (grant_idx),
    .resp    (alu_resp),
    .data    (alu_data),
    .res_tag (alu_tag)
  );

  // ALU output is zero when idle, so only the tagged port ever sees a nonzero value.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      if (alu_tag == 2'(p)) begin
        bus.out_resp[p+1] = alu_resp;
        bus.out_data[p+1] = alu_data;
      end else begin
        bus.out_resp[p+1] = '0;
        bus.out_data[p+1] = '0;
      end
    end
  end

  assign bus.drop_err = drop_err_q;
endmodule
